// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game: state codes and hold defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   STATE_W          width of the controller state code (also drives the debug LEDs)
//   RESULT_HOLD_DEF  default minimum dwell in S_RESULT before enter is honoured
//   HOLD_W_DEF       default hold counter width (2**HOLD_W_DEF > RESULT_HOLD_DEF)
//   state_t          controller state encoding, shared with the datapath and LED map
package game_pkg;

  localparam int STATE_W         = 4;
  localparam int RESULT_HOLD_DEF = 16;
  localparam int HOLD_W_DEF      = 5;

  // Codes are fixed: the LED mapping and the datapath decode them directly.
  // Codes 9..15 are unused and are treated as illegal by the controller.
  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_SETUP  = 4'd1,
    S_PREP   = 4'd2,
    S_FPGA   = 4'd3,
    S_USER   = 4'd4,
    S_CHECK  = 4'd5,
    S_NEXT   = 4'd6,
    S_EVAL   = 4'd7,
    S_RESULT = 4'd8
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge pulse generator.
// Latency: pulse is high in the cycle after the 2nd clock edge that sees the raw level.
// Backpressure: none; one single-cycle pulse per rising edge of the raw button.
//
// Ports:
//   clk        sampling clock
//   rst_n      asynchronous active-low clear of all flops
//   btn_raw    raw active-high button, asynchronous to clk
//   btn_pulse  one-cycle pulse on each synchronized 0->1 transition
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  logic sync0_q, sync0_d;
  logic sync1_q, sync1_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
    end
  end

  // Only the metastability-safe stage feeds the detector.
  assign btn_pulse = sync1_q & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Control FSM for the memory-sequence game; Moore outputs drive the datapath commands.
// Latency: outputs follow the state register directly; enter acts 2-3 cycles after its edge.
// Backpressure: none; status inputs are sampled every cycle, enter is gated by state/hold.
//
// Ports:
//   clock_50              system clock, rising edge
//   reset                 asynchronous active-low reset
//   enter                 raw player button (asynchronous)
//   end_fpga/end_user/end_time/win/match   datapath status
//   r1 r2                 game-level / round-level datapath resets
//   e1 e2 e3 e4           setup load / user entry / FPGA playback / round increment
//   sel                   display select: 1 = game status, 0 = result text
//   state_dbg             current state code
module game_controller
  import game_pkg::*;
#(
  parameter int RESULT_HOLD = RESULT_HOLD_DEF,
  // Must satisfy 2**HOLD_W > RESULT_HOLD so the saturation value is representable.
  parameter int HOLD_W      = HOLD_W_DEF
) (
  input  logic                clock_50,
  input  logic                reset,
  input  logic                enter,
  input  logic                end_fpga,
  input  logic                end_user,
  input  logic                end_time,
  input  logic                win,
  input  logic                match,
  output logic                r1,
  output logic                r2,
  output logic                e1,
  output logic                e2,
  output logic                e3,
  output logic                e4,
  output logic                sel,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESULT_HOLD);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                rls_q, rls_d;
  logic                enter_p;
  logic                hold_done;

  // ---------------------------------------------------------------------------
  // Enter button conditioning
  // ---------------------------------------------------------------------------
  btn_edge u_enter_edge (
    .clk       (clock_50),
    .rst_n     (reset),
    .btn_raw   (enter),
    .btn_pulse (enter_p)
  );

  // ---------------------------------------------------------------------------
  // Reset release
  // Reset asserts asynchronously, but the FSM only leaves S_INIT once this flop
  // has seen a clean edge with reset high. Together with the state register it
  // forms the two-stage release: first edge sets rls_q, second edge moves the FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    rls_d = 1'b1;
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      rls_q <= 1'b0;
    end else begin
      rls_q <= rls_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result hold counter
  // Zero in every state except S_RESULT, so it is already 0 in the first
  // S_RESULT cycle regardless of which path led there.
  // ---------------------------------------------------------------------------
  assign hold_done = (hold_cnt_q == HOLD_MAX);

  always_comb begin
    hold_cnt_d = '0;
    if (state_q == S_RESULT) begin
      hold_cnt_d = hold_done ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    r1      = 1'b0;
    r2      = 1'b0;
    e1      = 1'b0;
    e2      = 1'b0;
    e3      = 1'b0;
    e4      = 1'b0;
    sel     = 1'b1;

    case (state_q)
      S_INIT: begin
        r1 = 1'b1;
        r2 = 1'b1;
        if (rls_q) begin
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        e1 = 1'b1;
        if (enter_p) begin
          state_d = S_PREP;
        end
      end

      // Single-cycle round reset; playback only starts once it has been applied,
      // so r2 never overlaps e2/e3/e4.
      S_PREP: begin
        r2      = 1'b1;
        state_d = S_FPGA;
      end

      S_FPGA: begin
        e3 = 1'b1;
        if (end_fpga) begin
          state_d = S_USER;
        end
      end

      // A completed entry wins over a timeout arriving in the same cycle.
      S_USER: begin
        e2 = 1'b1;
        if (end_user) begin
          state_d = S_CHECK;
        end else if (end_time) begin
          state_d = S_RESULT;
        end
      end

      S_CHECK: begin
        state_d = match ? S_NEXT : S_RESULT;
      end

      S_NEXT: begin
        e4      = 1'b1;
        state_d = S_EVAL;
      end

      // win is sampled one cycle after the increment so it reflects the new count.
      S_EVAL: begin
        state_d = win ? S_RESULT : S_PREP;
      end

      S_RESULT: begin
        sel = 1'b0;
        if (enter_p && hold_done) begin
          state_d = S_INIT;
        end
      end

      // Unused codes recover through the game-level reset state.
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule
